// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder controller: latches operands, walks them LSB-first through an
// external 1-bit full adder, and presents the registered sum/carry with a done pulse.
module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             fa_A,
  output logic             fa_B,
  output logic             fa_Cin,
  input  logic             fa_S,
  input  logic             fa_Cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state, nextState;
  logic [WIDTH-1:0] aReg, bReg, sumReg, sumNext;
  logic             carryReg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    fa_A      = 1'b0;
    fa_B      = 1'b0;
    fa_Cin    = 1'b0;
    case (state)
      IDLE: if (start) nextState = RUN;
      RUN: begin
        fa_A   = aReg[cnt];
        fa_B   = bReg[cnt];
        fa_Cin = carryReg;
        if (cnt == LAST) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    sumNext      = sumReg;
    sumNext[cnt] = fa_S;
  end

  // Result registers are only loaded on the final bit so S/Cout hold the previous
  // answer while a new addition is still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      aReg     <= '0;
      bReg     <= '0;
      sumReg   <= '0;
      carryReg <= 1'b0;
      cnt      <= '0;
      S        <= '0;
      Cout     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          aReg     <= A;
          bReg     <= B;
          carryReg <= Cin;
          sumReg   <= '0;
          cnt      <= '0;
        end
        RUN: begin
          sumReg   <= sumNext;
          carryReg <= fa_Cout;
          if (cnt == LAST) begin
            S    <= sumNext;
            Cout <= fa_Cout;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed and random checks of bit_serial_add_ctrl at WIDTH=8 and WIDTH=1,
// each instance closed around a behavioural 1-bit full adder.
module tb_bit_serial_add_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       start;
  logic [7:0] A, B, S;
  logic       Cin, Cout, fa_A, fa_B, fa_Cin, fa_S, fa_Cout, busy, done;

  assign fa_S    = fa_A ^ fa_B ^ fa_Cin;
  assign fa_Cout = (fa_A & fa_B) | (fa_A & fa_Cin) | (fa_B & fa_Cin);

  bit_serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Cin(Cin),
    .fa_A(fa_A), .fa_B(fa_B), .fa_Cin(fa_Cin), .fa_S(fa_S), .fa_Cout(fa_Cout),
    .busy(busy), .done(done), .S(S), .Cout(Cout)
  );

  logic start1, A1, B1, Cin1, S1, Cout1, fa_A1, fa_B1, fa_Cin1, fa_S1, fa_Cout1, busy1, done1;

  assign fa_S1    = fa_A1 ^ fa_B1 ^ fa_Cin1;
  assign fa_Cout1 = (fa_A1 & fa_B1) | (fa_A1 & fa_Cin1) | (fa_B1 & fa_Cin1);

  bit_serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
    .fa_A(fa_A1), .fa_B(fa_B1), .fa_Cin(fa_Cin1), .fa_S(fa_S1), .fa_Cout(fa_Cout1),
    .busy(busy1), .done(done1), .S(S1), .Cout(Cout1)
  );

  // Drives a one-cycle start and returns negedges from acceptance until done (-1 on timeout).
  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic cin, output int lat);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, S, Cout, fa_A, fa_B, fa_Cin} !== 13'b0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b S=%h Cout=%b fa=%b%b%b, want all 0",
               busy, done, S, Cout, fa_A, fa_B, fa_Cin);
    end
    checks++;
    if ({busy1, done1, S1, Cout1, fa_A1, fa_B1, fa_Cin1} !== 7'b0) begin
      errors++;
      $display("FAIL reset1: got busy=%b done=%b S=%b Cout=%b, want all 0", busy1, done1, S1, Cout1);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] a;
    int busyBad, faBad;
    a = 8'h0F;
    busyBad = 0; faBad = 0;
    @(negedge clk);
    A = a; B = 8'h01; Cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) busyBad++;
      if (fa_A !== a[i] || fa_B !== (i == 0)) faBad++;
    end
    checks++;
    if (busyBad != 0) begin
      errors++;
      $display("FAIL basic_busy: busy/done wrong in %0d of 8 RUN cycles, want 0", busyBad);
    end
    checks++;
    if (faBad != 0) begin
      errors++;
      $display("FAIL basic_fa_bits: fa_A/fa_B wrong in %0d of 8 RUN cycles, want 0", faBad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || S !== 8'h10 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b busy=%b S=%h Cout=%b, want 1 0 10 0", done, busy, S, Cout);
    end
    checks++;
    if ({fa_A, fa_B, fa_Cin} !== 3'b0) begin
      errors++;
      $display("FAIL basic_fa_done: got fa=%b%b%b, want 000", fa_A, fa_B, fa_Cin);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || S !== 8'h10) begin
      errors++;
      $display("FAIL basic_hold: got done=%b S=%h, want 0 10", done, S);
    end
  endtask

  task automatic test_overflow;
    int lat;
    runOp(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 9 || S !== 8'h00 || Cout !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ff_01: got lat=%0d S=%h Cout=%b, want 9 00 1", lat, S, Cout);
    end
    runOp(8'hFF, 8'hFF, 1'b1, lat);
    checks++;
    if (lat !== 9 || S !== 8'hFF || Cout !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ff_ff_c: got lat=%0d S=%h Cout=%b, want 9 ff 1", lat, S, Cout);
    end
  endtask

  task automatic test_start_ignored;
    int doneCount;
    doneCount = 0;
    @(negedge clk);
    A = 8'h01; B = 8'h02; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'h55; B = 8'h55; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) begin
      if (done) doneCount++;
      @(negedge clk);
    end
    checks++;
    if (doneCount !== 1 || S !== 8'h03 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: got dones=%0d S=%h Cout=%b, want 1 03 0", doneCount, S, Cout);
    end
  endtask

  task automatic test_reset_mid_run;
    int doneCount, lat;
    doneCount = 0;
    @(negedge clk);
    A = 8'h12; B = 8'h34; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== 8'h00 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b S=%h Cout=%b, want 0 0 00 0", busy, done, S, Cout);
    end
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    checks++;
    if (doneCount !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d busy/done cycles after reset, want 0", doneCount);
    end
    runOp(8'h80, 8'h80, 1'b0, lat);
    checks++;
    if (lat !== 9 || S !== 8'h00 || Cout !== 1'b1) begin
      errors++;
      $display("FAIL reset_then_add: got lat=%0d S=%h Cout=%b, want 9 00 1", lat, S, Cout);
    end
  endtask

  task automatic test_width1;
    @(negedge clk);
    A1 = 1'b1; B1 = 1'b1; Cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || {fa_A1, fa_B1, fa_Cin1} !== 3'b111) begin
      errors++;
      $display("FAIL w1_run: got busy=%b done=%b fa=%b%b%b, want 1 0 111", busy1, done1, fa_A1, fa_B1, fa_Cin1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || S1 !== 1'b1 || Cout1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_done: got done=%b busy=%b S=%b Cout=%b, want 1 0 1 1", done1, busy1, S1, Cout1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || S1 !== 1'b1 || Cout1 !== 1'b1) begin
      errors++;
      $display("FAIL w1_hold: got done=%b S=%b Cout=%b, want 0 1 1", done1, S1, Cout1);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic       c;
    logic [8:0] ref9;
    int         lat, bad, faBad;
    bad = 0; faBad = 0;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom());
      b = 8'($urandom());
      c = 1'($urandom());
      ref9 = {1'b0, a} + {1'b0, b} + {8'b0, c};
      runOp(a, b, c, lat);
      if (lat !== 9 || {Cout, S} !== ref9) begin
        bad++;
        if (bad <= 5)
          $display("FAIL rand_sum: %h+%h+%b got lat=%0d %b_%h, want 9 %b_%h", a, b, c, lat, Cout, S, ref9[8], ref9[7:0]);
      end
      if ({fa_A, fa_B, fa_Cin} !== 3'b0) faBad++;
      @(negedge clk);
      if ({fa_A, fa_B, fa_Cin, busy, done} !== 5'b0) faBad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_total: got %0d wrong results, want 0", bad);
    end
    checks++;
    if (faBad != 0) begin
      errors++;
      $display("FAIL rand_fa_idle: got %0d nonzero fa/idle samples outside RUN, want 0", faBad);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    start1 = 1'b0; A1 = 1'b0; B1 = 1'b0; Cin1 = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_start_ignored();
    test_reset_mid_run();
    test_width1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_add_ctrl.md
BIT_SERIAL_ADD_CTRL -- requirements
Module: bit_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1..32).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled each rising edge.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand A, sampled only when start is accepted.
REQ-007 The block SHALL have port B, input, WIDTH bits: operand B, sampled only when start is accepted.
REQ-008 The block SHALL have port Cin, input, 1 bit: carry-in, sampled only when start is accepted.
REQ-009 The block SHALL have port fa_A, output, 1 bit: A operand bit to the external 1-bit full adder.
REQ-010 The block SHALL have port fa_B, output, 1 bit: B operand bit to the external full adder.
REQ-011 The block SHALL have port fa_Cin, output, 1 bit: carry bit to the external full adder.
REQ-012 The block SHALL have port fa_S, input, 1 bit: sum bit returned combinationally by the full adder.
REQ-013 The block SHALL have port fa_Cout, input, 1 bit: carry-out returned combinationally by the full adder.
REQ-014 The block SHALL have port busy, output, 1 bit: high while an addition is in progress (state RUN).
REQ-015 The block SHALL have port done, output, 1 bit: single-cycle pulse, high when the result is valid.
REQ-016 The block SHALL have port S, output, WIDTH bits: registered sum result.
REQ-017 The block SHALL have port Cout, output, 1 bit: registered final carry-out.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 In IDLE with start=1, the block SHALL, at that edge, latch A, B and Cin into internal registers, clear the bit counter to 0 and enter RUN.
REQ-020 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-021 Start SHALL be ignored in RUN and DONE, with no effect on operands, counter or result.
REQ-022 In RUN, fa_A and fa_B SHALL be bit [cnt] of the latched A and B, and fa_Cin SHALL be the carry register (combinational from state and registers).
REQ-023 In RUN, each edge SHALL write fa_S into sum bit [cnt], load the carry register from fa_Cout, and increment cnt.
REQ-024 The block SHALL transition from RUN to DONE on the edge that captures bit WIDTH-1; RUN SHALL last exactly WIDTH cycles.
REQ-025 DONE SHALL last one cycle, with done=1, S equal to the full sum and Cout equal to the carry register, and SHALL then return to IDLE.
REQ-026 Latency SHALL be fixed: if start is accepted at edge k, done is high in the cycle following edge k+WIDTH.
REQ-027 The counter SHALL be max(1,clog2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-028 For WIDTH=1, RUN SHALL last exactly one cycle.
REQ-029 S and Cout SHALL hold their last result through DONE and IDLE until the next accepted start.
REQ-030 The result SHALL equal {Cout,S} = A + B + Cin modulo 2^(WIDTH+1), with no overflow flag.
REQ-031 Outside RUN, fa_A, fa_B and fa_Cin SHALL be 0.

Reset
REQ-032 With reset=1 at an edge, the block SHALL enter IDLE and set busy=0, done=0, S=0, Cout=0, cnt=0, the carry register to 0, and the operand registers to 0.
REQ-033 Reset SHALL take priority over start and over any in-progress RUN or DONE; a reset mid-operation SHALL discard the partial result with no done pulse.
REQ-034 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-035 For WIDTH=8, start with A=0x0F, B=0x01, Cin=0 at edge 0 -> busy high for edges 1..8, done high the following cycle, S=0x10, Cout=0.
REQ-036 For A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1; for A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Cout=1.
REQ-037 Start pulsed with A=0x55 during RUN of A=0x01+B=0x02 -> result S=0x03, only one done pulse, second request lost.
REQ-038 Reset asserted on the 4th RUN cycle -> next cycle IDLE, busy=0, S=0, Cout=0, no done; a subsequent start with 0x80+0x80 yields S=0x00, Cout=1.
REQ-039 For WIDTH=1, A=1, B=1, Cin=1 -> done in the cycle after the edge following acceptance, S=1, Cout=1.
REQ-040 A random regression of 1000 operand sets against a reference sum SHALL show every result correct and fa_* equal to 0 outside RUN.
